uart_rx: RTL and testbench

UART receiver: the receive-side counterpart of the team's UART transmitter. It synchronizes the serial line, detects the start bit, oversamples each bit, majority-votes the mid-bit samples, and deserializes LSB-first data with optional parity. It delivers a parallel word plus a one-cycle valid pulse and error flags to the host-side logic.

---
 rtl/uart_pkg.sv | 22 ++
 rtl/uart_rx_sampler.sv | 49 ++++
 rtl/uart_rx.sv | 138 +++++++++++++
 tb/tb_uart_rx.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART types, line levels and parity encodings
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } rx_state_t;

    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;

    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

    function automatic logic majority3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// rtl/uart_rx_sampler.sv - per-bit oversampling counter and 3-sample majority vote
module uart_rx_sampler
    import uart_pkg::*;
#(
    parameter int OVERSAMPLE = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic active,
    input  logic rx_s,
    output logic bit_done,
    output logic bit_end,
    output logic bit_val
);

    localparam int H  = OVERSAMPLE / 2;
    localparam int CW = $clog2(OVERSAMPLE);

    localparam logic [CW-1:0] LAST_CNT = CW'(OVERSAMPLE - 1);
    localparam logic [CW-1:0] SAMPLE_0 = CW'(H - 1);
    localparam logic [CW-1:0] SAMPLE_1 = CW'(H);
    localparam logic [CW-1:0] DECIDE   = CW'(H + 1);

    logic [CW-1:0] edge_cnt;
    logic [CW-1:0] cnt_nxt;
    logic [1:0]    samples;

    assign cnt_nxt = (edge_cnt == LAST_CNT) ? '0 : edge_cnt + CW'(1);

    // Each sample is tagged with the edge_cnt value loaded on the same edge,
    // so the third sample is the live rx_s on the decision edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            edge_cnt <= '0;
            samples  <= 2'b11;
        end else if (!active) begin
            edge_cnt <= '0;
        end else begin
            edge_cnt <= cnt_nxt;
            if (cnt_nxt == SAMPLE_0) samples[0] <= rx_s;
            if (cnt_nxt == SAMPLE_1) samples[1] <= rx_s;
        end
    end

    assign bit_done = active && (cnt_nxt == DECIDE);
    assign bit_end  = active && (edge_cnt == LAST_CNT);
    assign bit_val  = majority3(samples[0], samples[1], rx_s);

endmodule

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - UART receiver: synchronizer, frame FSM, deserializer, parity/stop check
module uart_rx
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int OVERSAMPLE = 8
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  RX_IN,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    output logic [DATA_WIDTH-1:0] P_DATA,
    output logic                  DATA_VALID,
    output logic                  PAR_ERR,
    output logic                  STP_ERR,
    output logic                  BUSY
);

    localparam int CNT_W = $clog2(DATA_WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH);

    rx_state_t state, state_nxt;

    logic                  sync_1;
    logic                  rx_s;
    logic                  bit_done;
    logic                  bit_end;
    logic                  bit_val;
    logic [DATA_WIDTH-1:0] shift;
    logic [CNT_W-1:0]      bit_cnt;
    logic                  par_en_q;
    logic                  par_typ_q;
    logic                  par_mismatch;
    logic                  exp_parity;
    logic                  start_seen;
    logic                  stop_done;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            sync_1 <= 1'b1;
            rx_s   <= 1'b1;
        end else begin
            sync_1 <= RX_IN;
            rx_s   <= sync_1;
        end
    end

    uart_rx_sampler #(
        .OVERSAMPLE(OVERSAMPLE)
    ) u_sampler (
        .clk     (CLK),
        .rst     (RST),
        .active  (state != IDLE),
        .rx_s    (rx_s),
        .bit_done(bit_done),
        .bit_end (bit_end),
        .bit_val (bit_val)
    );

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) state <= IDLE;
        else     state <= state_nxt;
    end

    // STOP leaves at the decision point, not the bit end, so a start edge
    // directly after the stop bit still finds the FSM in IDLE.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (rx_s == START_BIT) state_nxt = START;
            end
            START: begin
                if (bit_done && bit_val != START_BIT) state_nxt = IDLE;
                else if (bit_end)                     state_nxt = DATA;
            end
            DATA: begin
                if (bit_end && bit_cnt == LAST_BIT) state_nxt = par_en_q ? PARITY : STOP;
            end
            PARITY: begin
                if (bit_end) state_nxt = STOP;
            end
            STOP: begin
                if (bit_done) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign start_seen = (state == IDLE) && (state_nxt == START);
    assign stop_done  = (state == STOP) && bit_done;
    assign exp_parity = (^shift) ^ (par_typ_q == PAR_ODD);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            shift        <= '0;
            bit_cnt      <= '0;
            par_en_q     <= 1'b0;
            par_typ_q    <= PAR_EVEN;
            par_mismatch <= 1'b0;
            P_DATA       <= '0;
            DATA_VALID   <= 1'b0;
            PAR_ERR      <= 1'b0;
            STP_ERR      <= 1'b0;
            BUSY         <= 1'b0;
        end else begin
            DATA_VALID <= 1'b0;
            PAR_ERR    <= 1'b0;
            STP_ERR    <= 1'b0;
            BUSY       <= (state_nxt != IDLE);

            if (start_seen) begin
                par_en_q     <= PAR_EN;
                par_typ_q    <= PAR_TYP;
                bit_cnt      <= '0;
                par_mismatch <= 1'b0;
            end

            if (state == DATA && bit_done) begin
                shift   <= {bit_val, shift[DATA_WIDTH-1:1]};
                bit_cnt <= bit_cnt + CNT_W'(1);
            end

            if (state == PARITY && bit_done) par_mismatch <= (bit_val != exp_parity);

            if (stop_done) begin
                STP_ERR <= (bit_val != STOP_BIT);
                PAR_ERR <= par_mismatch;
                if (bit_val == STOP_BIT && !par_mismatch) begin
                    DATA_VALID <= 1'b1;
                    P_DATA     <= shift;
                end
            end
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - self-checking bench for uart_rx (vector table, directed corners, random frames)
module tb_uart_rx;

    localparam int DW = 8;
    localparam int OS = 8;
    localparam int H  = OS / 2;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          rx_in = 1'b1;
    logic          par_en = 1'b0;
    logic          par_typ = 1'b0;
    logic [DW-1:0] p_data;
    logic          data_valid, par_err, stp_err, busy;

    uart_rx #(.DATA_WIDTH(DW), .OVERSAMPLE(OS)) dut (
        .CLK       (clk),
        .RST       (rst),
        .RX_IN     (rx_in),
        .PAR_EN    (par_en),
        .PAR_TYP   (par_typ),
        .P_DATA    (p_data),
        .DATA_VALID(data_valid),
        .PAR_ERR   (par_err),
        .STP_ERR   (stp_err),
        .BUSY      (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       dv, pe, se, bz;
        logic [7:0] pd;
        int         lat;
    } ev_t;

    typedef struct {
        logic [7:0] data;
        logic       pen, ptyp, pbit, stopb;
        logic       exp_dv, exp_pe, exp_se;
        logic [7:0] exp_pd;
    } vec_t;

    ev_t  evq[$];
    ev_t  ev_new;
    int   cyc = 0;
    int   rise_cyc = 0;
    int   busy_rises = 0;
    logic busy_q = 1'b0;
    int   n_checks = 0;
    int   n_pass = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (busy && !busy_q) begin
            rise_cyc = cyc;
            busy_rises++;
        end
        busy_q = busy;
        if (data_valid || par_err || stp_err) begin
            ev_new.dv  = data_valid;
            ev_new.pe  = par_err;
            ev_new.se  = stp_err;
            ev_new.bz  = busy;
            ev_new.pd  = p_data;
            ev_new.lat = cyc - rise_cyc;
            evq.push_back(ev_new);
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // skew: 0 ideal, +1/-1 alternate long/short bits starting with that sign
    task automatic send_frame(input logic [7:0] d, input logic pen, input logic ptyp,
                              input logic pbit, input logic stopb, input int skew,
                              input int spike_bit, input int gap, input logic scramble);
        logic [11:0] b;
        int          nb;
        int          len;
        par_en  = pen;
        par_typ = ptyp;
        b = '0;
        b[0] = 1'b0;
        for (int i = 0; i < DW; i++) b[1+i] = d[i];
        nb = DW + 1;
        if (pen) begin
            b[nb] = pbit;
            nb++;
        end
        b[nb] = stopb;
        nb++;
        for (int i = 0; i < nb; i++) begin
            len = OS + ((i % 2 == 0) ? skew : -skew);
            for (int c = 0; c < len; c++) begin
                rx_in = (i == spike_bit && c == H + 1) ? ~b[i] : b[i];
                if (scramble && i == 2 && c == 0) begin
                    par_en  = 1'($urandom);
                    par_typ = 1'($urandom);
                end
                step(1);
            end
        end
        rx_in = 1'b1;
        step(gap);
    endtask

    task automatic expect_ev(input string tag, input logic edv, input logic epe,
                             input logic ese, input logic [7:0] epd, input int elat);
        ev_t e;
        int  t;
        t = 0;
        while (evq.size() == 0 && t < 200) begin
            step(1);
            t++;
        end
        chk({tag, " event"}, evq.size() > 0 ? 1 : 0, 1);
        if (evq.size() > 0) begin
            e = evq.pop_front();
            chk({tag, " data_valid"}, e.dv, edv);
            chk({tag, " par_err"}, e.pe, epe);
            chk({tag, " stp_err"}, e.se, ese);
            chk({tag, " p_data"}, e.pd, epd);
            chk({tag, " busy_at_pulse"}, e.bz, 0);
            if (elat >= 0) chk({tag, " latency"}, e.lat, elat);
        end
    endtask

    vec_t       vecs[9];
    logic [7:0] model_pd;
    logic [7:0] rd;
    logic       rpen, rptyp, rpbit, rstop;
    logic       m_dv, m_pe, m_se;
    int         rskew;
    int         rises0;

    initial begin
        vecs[0] = '{8'hA5, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'hA5};
        vecs[1] = '{8'h3C, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h3C};
        vecs[2] = '{8'h3C, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'h3C};
        vecs[3] = '{8'h3C, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 8'h3C};
        vecs[4] = '{8'h55, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h3C};
        vecs[5] = '{8'h0F, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h0F};
        vecs[6] = '{8'h12, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'h0F};
        vecs[7] = '{8'h00, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00};
        vecs[8] = '{8'hFF, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'hFF};

        step(3);
        chk("reset p_data", p_data, 0);
        chk("reset data_valid", data_valid, 0);
        chk("reset par_err", par_err, 0);
        chk("reset stp_err", stp_err, 0);
        chk("reset busy", busy, 0);
        rst = 1'b0;
        step(10);

        for (int i = 0; i < 9; i++) begin
            send_frame(vecs[i].data, vecs[i].pen, vecs[i].ptyp, vecs[i].pbit, vecs[i].stopb,
                       0, -1, 16, 1'b0);
            expect_ev($sformatf("vec%0d", i), vecs[i].exp_dv, vecs[i].exp_pe, vecs[i].exp_se,
                      vecs[i].exp_pd, (1 + DW + (vecs[i].pen ? 1 : 0)) * OS + H + 1);
            chk($sformatf("vec%0d busy_after", i), busy, 0);
        end
        model_pd = 8'hFF;

        rises0 = busy_rises;
        rx_in = 1'b0;
        step(2);
        rx_in = 1'b1;
        step(20);
        chk("glitch busy_pulse", busy_rises - rises0, 1);
        chk("glitch no_flags", evq.size(), 0);
        chk("glitch busy_low", busy, 0);
        send_frame(8'h81, 1'b0, 1'b0, 1'b0, 1'b1, 0, -1, 16, 1'b0);
        expect_ev("after_glitch", 1'b1, 1'b0, 1'b0, 8'h81, -1);

        send_frame(8'h5A, 1'b0, 1'b0, 1'b0, 1'b1, 0, 3, 16, 1'b0);
        expect_ev("spike_data", 1'b1, 1'b0, 1'b0, 8'h5A, -1);
        send_frame(8'hC3, 1'b1, 1'b1, 1'b1, 1'b1, 0, 0, 16, 1'b0);
        expect_ev("spike_start", 1'b1, 1'b0, 1'b0, 8'hC3, -1);

        send_frame(8'h01, 1'b0, 1'b0, 1'b0, 1'b1, 1, -1, 0, 1'b0);
        send_frame(8'hFE, 1'b0, 1'b0, 1'b0, 1'b1, -1, -1, 16, 1'b0);
        expect_ev("b2b_first", 1'b1, 1'b0, 1'b0, 8'h01, -1);
        expect_ev("b2b_second", 1'b1, 1'b0, 1'b0, 8'hFE, -1);
        send_frame(8'h3C, 1'b0, 1'b0, 1'b0, 1'b1, -1, -1, 0, 1'b0);
        send_frame(8'hC5, 1'b1, 1'b0, 1'b0, 1'b1, 1, -1, 16, 1'b0);
        expect_ev("b2b_skew_a", 1'b1, 1'b0, 1'b0, 8'h3C, -1);
        expect_ev("b2b_skew_b", 1'b1, 1'b0, 1'b0, 8'hC5, -1);

        par_en = 1'b0;
        rx_in = 1'b0;
        step(OS);
        for (int i = 0; i < 3; i++) begin
            rx_in = (i % 2 == 1);
            step(OS);
        end
        #2 rst = 1'b1;
        #1;
        chk("midreset p_data", p_data, 0);
        chk("midreset busy", busy, 0);
        chk("midreset flags", {data_valid, par_err, stp_err}, 0);
        rx_in = 1'b1;
        step(3);
        rst = 1'b0;
        step(40);
        chk("midreset no_pulse", evq.size(), 0);
        send_frame(8'h77, 1'b0, 1'b0, 1'b0, 1'b1, 0, -1, 16, 1'b0);
        expect_ev("after_reset", 1'b1, 1'b0, 1'b0, 8'h77, -1);
        model_pd = 8'h77;

        for (int r = 0; r < 40; r++) begin
            rd    = 8'($urandom);
            rpen  = 1'($urandom);
            rptyp = 1'($urandom);
            rpbit = 1'($urandom);
            rstop = ($urandom_range(0, 3) != 0);
            rskew = int'($urandom_range(0, 2)) - 1;
            m_pe = rpen && (($countones({rd, rpbit}) % 2) != (rptyp ? 1 : 0));
            m_se = !rstop;
            m_dv = !m_pe && !m_se;
            if (m_dv) model_pd = rd;
            send_frame(rd, rpen, rptyp, rpbit, rstop, rskew, -1, 16, 1'b1);
            expect_ev($sformatf("rand%0d", r), m_dv, m_pe, m_se, model_pd, -1);
        end
        chk("final no_extra_events", evq.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, checks %0d/%0d", n_pass, n_checks);
        $fatal(1);
    end

endmodule
